// File: rtl/common.sv
// Shared types for the ALU / multiply-divide unit: operation codes and FSM states.
package common;

    typedef enum logic [4:0] {
        ALU_AND    = 5'h00,
        ALU_OR     = 5'h01,
        ALU_XOR    = 5'h02,
        ALU_ADD    = 5'h03,
        ALU_SUB    = 5'h04,
        ALU_SLT    = 5'h05,
        ALU_SLTU   = 5'h06,
        ALU_SLL    = 5'h07,
        ALU_SRL    = 5'h08,
        ALU_SRA    = 5'h09,
        ALU_MUL    = 5'h10,
        ALU_MULH   = 5'h11,
        ALU_MULHSU = 5'h12,
        ALU_MULHU  = 5'h13,
        ALU_DIV    = 5'h14,
        ALU_DIVU   = 5'h15,
        ALU_REM    = 5'h16,
        ALU_REMU   = 5'h17
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/div_iter.sv
// One restoring-division step on unsigned magnitudes. The quotient register
// doubles as the dividend shifter: its MSB feeds the partial remainder while
// the new quotient bit enters at the LSB.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtract; a borrow (diff MSB set) restores the shifted remainder.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[WIDTH]) begin
            rem_out = shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Single-cycle RV32I-style ALU plus iterative M-extension multiply/divide.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; base ops and trivial divides complete from here
// ST_MUL  | shift-add multiply, one product bit per cycle
// ST_DIV  | restoring divide, one quotient bit per cycle
// ST_DONE | result_valid cycle for an iterative op; returns to idle
module alu_muldiv
    import common::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic [4:0]       control,
    input  logic [WIDTH-1:0] left_operand,
    input  logic [WIDTH-1:0] right_operand,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag
);

    localparam int               CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    fsm_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
    logic             neg_res_q, neg_rem_q, hi_sel_q, rem_sel_q;

    logic [WIDTH-1:0] base_res;
    logic             one_cycle, is_div, a_signed, b_signed;
    logic             launch, iter_active, last_iter, a_neg, b_neg;
    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n, mul_lo_n, div_rem_n, div_quo_n;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   div_rem_s, div_quo_s, iter_res;

    assign busy        = (state_q != ST_IDLE);
    assign launch      = start && !busy && !flush;
    assign iter_active = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign last_iter   = (cnt_q == LAST_ITER);
    assign shamt       = right_operand[CW-1:0];

    // Decode: one-cycle result and operand signedness for the iterative ops.
    // Divide-by-zero and signed overflow are resolved here so they never iterate.
    always_comb begin
        base_res  = '0;
        one_cycle = 1'b1;
        is_div    = 1'b0;
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        case (control)
            ALU_AND:  base_res = left_operand & right_operand;
            ALU_OR:   base_res = left_operand | right_operand;
            ALU_XOR:  base_res = left_operand ^ right_operand;
            ALU_ADD:  base_res = left_operand + right_operand;
            ALU_SUB:  base_res = left_operand - right_operand;
            ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(left_operand) < $signed(right_operand))};
            ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, (left_operand < right_operand)};
            ALU_SLL:  base_res = left_operand << shamt;
            ALU_SRL:  base_res = left_operand >> shamt;
            ALU_SRA:  base_res = $signed(left_operand) >>> shamt;
            ALU_MUL, ALU_MULH: begin
                one_cycle = 1'b0;
                a_signed  = 1'b1;
                b_signed  = 1'b1;
            end
            ALU_MULHSU: begin
                one_cycle = 1'b0;
                a_signed  = 1'b1;
            end
            ALU_MULHU: one_cycle = 1'b0;
            ALU_DIV, ALU_REM: begin
                is_div   = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
                if (right_operand == '0)
                    base_res = (control == ALU_DIV) ? '1 : left_operand;
                else if (left_operand == MOST_NEG && right_operand == '1)
                    base_res = (control == ALU_DIV) ? MOST_NEG : '0;
                else
                    one_cycle = 1'b0;
            end
            ALU_DIVU, ALU_REMU: begin
                is_div = 1'b1;
                if (right_operand == '0)
                    base_res = (control == ALU_DIVU) ? '1 : left_operand;
                else
                    one_cycle = 1'b0;
            end
            default: base_res = '0;
        endcase
    end

    assign a_neg = a_signed && left_operand[WIDTH-1];
    assign b_neg = b_signed && right_operand[WIDTH-1];
    assign a_mag = a_neg ? -left_operand  : left_operand;
    assign b_mag = b_neg ? -right_operand : right_operand;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; flush overrides everything, including a same-cycle start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch && !one_cycle) state_d = is_div ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (last_iter) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Multiply step: add multiplicand into the high half when the multiplier LSB is set, then shift right.
    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .rem_in  (acc_hi_q),
        .quo_in  (acc_lo_q),
        .divisor (opnd_q),
        .rem_out (div_rem_n),
        .quo_out (div_quo_n)
    );

    // Sign restoration applied to the final iteration's value.
    assign prod      = {mul_hi_n, mul_lo_n};
    assign prod_s    = neg_res_q ? -prod : prod;
    assign div_rem_s = neg_rem_q ? -div_rem_n : div_rem_n;
    assign div_quo_s = neg_res_q ? -div_quo_n : div_quo_n;
    assign iter_res  = (state_q == ST_DIV) ? (rem_sel_q ? div_rem_s : div_quo_s)
                                           : (hi_sel_q ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0]);

    // Operand capture at launch, then one iteration per cycle; counter saturates at the last iteration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_sel_q  <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (launch) begin
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= is_div ? a_mag : b_mag;
            opnd_q    <= is_div ? b_mag : a_mag;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            hi_sel_q  <= (control == ALU_MULH) || (control == ALU_MULHSU) || (control == ALU_MULHU);
            rem_sel_q <= (control == ALU_REM) || (control == ALU_REMU);
        end else if (iter_active) begin
            acc_hi_q <= (state_q == ST_DIV) ? div_rem_n : mul_hi_n;
            acc_lo_q <= (state_q == ST_DIV) ? div_quo_n : mul_lo_n;
            if (!last_iter) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Result register: one-cycle ops publish at launch, iterative ops on the last iteration unless flushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_valid <= 1'b0;
            result       <= '0;
            zero_flag    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (launch && one_cycle) begin
                result_valid <= 1'b1;
                result       <= base_res;
                zero_flag    <= (base_res == '0);
            end else if (iter_active && last_iter && !flush) begin
                result_valid <= 1'b1;
                result       <= iter_res;
                zero_flag    <= (iter_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: drivers push expected results, monitors pop on result_valid.
`timescale 1ns/1ps
module tb_alu_muldiv;
    import common::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic        start, flush, busy, result_valid, zero_flag;
    logic [4:0]  control;
    logic [31:0] left_operand, right_operand, result;

    logic        start8, flush8, busy8, valid8, zf8;
    logic [4:0]  control8;
    logic [7:0]  a8, b8, result8;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .control(control),
        .left_operand(left_operand), .right_operand(right_operand), .busy(busy),
        .result_valid(result_valid), .result(result), .zero_flag(zero_flag)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .flush(flush8), .control(control8),
        .left_operand(a8), .right_operand(b8), .busy(busy8),
        .result_valid(valid8), .result(result8), .zero_flag(zf8)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (q32.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid32: result 0x%08h at cycle %0d", result, cyc);
            end else begin
                e32 = q32.pop_front();
                check({e32.name, "_result"}, result, e32.res);
                check({e32.name, "_zero"}, {31'b0, zero_flag}, {31'b0, (e32.res == 32'h0)});
                check({e32.name, "_cycle"}, cyc, e32.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (valid8 === 1'b1) begin
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid8: result 0x%02h at cycle %0d", result8, cyc);
            end else begin
                e8 = q8.pop_front();
                check({e8.name, "_result"}, {24'b0, result8}, e8.res);
                check({e8.name, "_zero"}, {31'b0, zf8}, {31'b0, (e8.res == 32'h0)});
                check({e8.name, "_cycle"}, cyc, e8.cyc);
            end
        end
    end

    task automatic issue32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat, input string nm, input bit push);
        control       = op;
        left_operand  = a;
        right_operand = b;
        start         = 1'b1;
        if (push) q32.push_back('{exp, cyc + lat, nm});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp, input string nm);
        control8 = op;
        a8       = a;
        b8       = b;
        start8   = 1'b1;
        q8.push_back('{{24'b0, exp}, cyc + 9, nm});
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic busy_run32(input string nm, input int expect_cycles);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check({nm, "_busy_cycles"}, n, expect_cycles);
    endtask

    task automatic busy_run8(input string nm);
        int n = 0;
        while (busy8 === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check({nm, "_busy_cycles"}, n, 9);
    endtask

    vec_t base_vecs [15] = '{
        '{ALU_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234},
        '{ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F},
        '{ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F},
        '{ALU_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE},
        '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
        '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
        '{ALU_SLL,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000},
        '{ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000},
        '{ALU_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
        '{5'h0A,    32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
        '{5'h1F,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
        '{ALU_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
        '{ALU_REM,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
        '{ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
    };

    vec_t m_vecs [11] = '{
        '{ALU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{ALU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
        '{ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
        '{ALU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{ALU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{ALU_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E},
        '{ALU_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002},
        '{ALU_DIV,    32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2},
        '{ALU_REM,    32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002}
    };

    initial begin
        start = 1'b0; flush = 1'b0; control = '0; left_operand = '0; right_operand = '0;
        start8 = 1'b0; flush8 = 1'b0; control8 = '0; a8 = '0; b8 = '0;

        #2 reset_n = 1'b0;
        #1;
        check("reset_result", result, 32'h0);
        check("reset_zero", {31'b0, zero_flag}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_valid", {31'b0, result_valid}, 32'h0);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;

        // First edge after release must launch.
        issue32(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, "add_ovf", 1'b1);
        check("add_ovf_busy", {31'b0, busy}, 32'h0);

        for (int i = 0; i < 15; i++) begin
            issue32(base_vecs[i].op, base_vecs[i].a, base_vecs[i].b, base_vecs[i].exp, 1,
                    $sformatf("base%0d", i), 1'b1);
            check($sformatf("base%0d_busy", i), {31'b0, busy}, 32'h0);
        end

        for (int i = 0; i < 11; i++) begin
            issue32(m_vecs[i].op, m_vecs[i].a, m_vecs[i].b, m_vecs[i].exp, 33,
                    $sformatf("mop%0d", i), 1'b1);
            busy_run32($sformatf("mop%0d", i), 33);
        end

        // Starts during busy are dropped.
        issue32(ALU_MUL, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_spam", 1'b1);
        for (int i = 0; i < 10; i++) begin
            control = ALU_ADD; left_operand = 32'h1; right_operand = 32'h1; start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        busy_run32("mul_spam", 23);

        // Flush during iteration 12, then flush colliding with a start.
        issue32(ALU_DIVU, 32'd1000, 32'd3, 32'h0, 33, "div_flushed", 1'b0);
        repeat (11) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'h0);
        check("flush_result_kept", result, 32'hFFFF_FFEB);
        check("flush_zero_kept", {31'b0, zero_flag}, 32'h0);
        flush = 1'b1;
        issue32(ALU_ADD, 32'h1, 32'h1, 32'h2, 1, "flush_start", 1'b0);
        flush = 1'b0;
        check("flush_start_busy", {31'b0, busy}, 32'h0);
        check("flush_start_result", result, 32'hFFFF_FFEB);
        repeat (40) begin @(posedge clk); #1; end
        issue32(ALU_ADD, 32'h2, 32'h2, 32'h4, 1, "after_flush", 1'b1);

        // Async reset in the middle of a divide.
        issue32(ALU_DIV, 32'd100, 32'd7, 32'h0, 33, "div_reset", 1'b0);
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midreset_result", result, 32'h0);
        check("midreset_zero", {31'b0, zero_flag}, 32'h0);
        check("midreset_busy", {31'b0, busy}, 32'h0);
        check("midreset_valid", {31'b0, result_valid}, 32'h0);
        #10 reset_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        issue32(ALU_SUB, 32'h5, 32'h5, 32'h0, 1, "sub_zero", 1'b1);

        // Narrow build.
        issue8(ALU_MULHSU, 8'hFF, 8'h02, 8'hFF, "w8_mulhsu");
        busy_run8("w8_mulhsu");
        issue8(ALU_REMU, 8'd200, 8'd7, 8'd4, "w8_remu");
        busy_run8("w8_remu");
        issue8(ALU_DIV, 8'hF9, 8'h02, 8'hFD, "w8_div");
        busy_run8("w8_div");
        issue8(ALU_MUL, 8'h10, 8'h10, 8'h00, "w8_mul");
        busy_run8("w8_mul");

        repeat (5) begin @(posedge clk); #1; end
        check("pending32", q32.size(), 32'h0);
        check("pending8", q8.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; SHALL be an even value of at least 8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  request; sampled high while busy=0 launches one operation.
REQ-005 flush  input  1  aborts any in-flight operation; result is discarded.
REQ-006 control  input  5  operation code (alu_op_t from package common).
REQ-007 left_operand  input  WIDTH  operand A, captured at launch.
REQ-008 right_operand  input  WIDTH  operand B, captured at launch.
REQ-009 busy  output  1  high while an operation is in flight; start is ignored.
REQ-010 result_valid  output  1  single-cycle pulse marking a valid result.
REQ-011 result  output  WIDTH  registered result; holds its value until the next result_valid.
REQ-012 zero_flag  output  1  registered; equals (result == 0), updated with result_valid.

Function
REQ-013 Base ops are AND, OR, XOR, ADD, SUB, SLT, SLTU, SLL, SRL, SRA: RV32I semantics, modulo-2^WIDTH, shift amount = B[$clog2(WIDTH)-1:0].
REQ-014 Base ops SHALL assert result_valid exactly 1 cycle after launch and SHALL NOT assert busy.
REQ-015 M ops are MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: RISC-V M semantics at width WIDTH.
REQ-016 MUL* SHALL use a radix-2 shift-add over a 2*WIDTH-bit product, with sign correction for the signed variants.
REQ-017 MUL returns the low WIDTH bits; MULH, MULHSU and MULHU return the high WIDTH bits.
REQ-018 DIV/REM SHALL use restoring division on magnitudes; the quotient takes sign A^B and the remainder takes the sign of A.
REQ-019 FSM states: IDLE, MUL, DIV, DONE; launch moves IDLE to MUL or DIV; after WIDTH iterations the FSM moves to DONE; DONE moves to IDLE.
REQ-020 M-op latency: busy is high for cycles 1..WIDTH+1 after launch; result_valid pulses in cycle WIDTH+1; busy drops in the same cycle.
REQ-021 The iteration counter SHALL count 0..WIDTH-1 and SHALL NOT wrap; it is cleared at each launch.
REQ-022 Divide by zero: DIV/DIVU return all ones and REM/REMU return A, both with base-op latency (1 cycle, no busy).
REQ-023 Signed overflow (A = most-negative, B = -1): DIV returns A and REM returns 0, with base-op latency.
REQ-024 start while busy=1 is ignored, with no queuing and no error.
REQ-025 start on the cycle busy falls is ignored; the next launch is allowed one cycle later.
REQ-026 flush: next cycle FSM=IDLE, busy=0, no result_valid; result and zero_flag keep their previous values.
REQ-027 flush and start in the same cycle: flush wins and the start is dropped.
REQ-028 An undefined control value SHALL behave as a base op returning 0, with zero_flag=1.

Reset
REQ-029 reset_n low SHALL immediately force FSM=IDLE, busy=0, result_valid=0, result=0, zero_flag=0 and counter=0.
REQ-030 Reset asserted mid-operation abandons the operation; no result_valid follows its release.
REQ-031 The first launch SHALL be accepted on the first rising edge with reset_n high.

Structure
REQ-032 Package common SHALL hold alu_op_t (5-bit enum covering the base ALU_* and the M-op codes) and the FSM state typedef.
REQ-033 The restoring division datapath SHALL be the sub-module div_iter (WIDTH parameter, one iteration per cycle); multiplication stays inline.
REQ-034 Operand capture registers SHALL be loaded only at launch, so the operand inputs are don't-care while busy.

Verification
REQ-035 ADD 0x7FFFFFFF + 1 -> one cycle later result=0x80000000, zero_flag=0, busy never high.
REQ-036 MULH 0x80000000 * 0x80000000 -> result_valid in cycle 33, result=0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-037 DIV -7 / 2 -> quotient 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 5 / 0 -> 0xFFFFFFFF in 1 cycle; DIV 0x80000000 / -1 -> 0x80000000.
REQ-038 start pulsed on cycles 1..10 during an M op -> exactly one result_valid; flush at iteration 12 -> no result_valid, busy=0 the next cycle.
REQ-039 reset_n pulled low mid-DIV -> outputs go to reset values asynchronously; SUB 5 - 5 after release -> result=0, zero_flag=1.
REQ-040 WIDTH=8 build: MULHSU 0xFF * 0x02 -> 0xFF; REMU 200 % 7 -> 4; result_valid in cycle 9.
